// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU control codes and FSM states.
package alu_pkg;

   // ALU control codes; the arbiter forwards them untouched, these name the known ones.
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner,
// so the previous winner has lowest priority.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] last_grant,
   output logic [NREQ-1:0] gnt,
   output logic [IDXW-1:0] gnt_idx
);

   logic found;
   int   cand;

   // First requester found walking forward from last_grant+1 (wrapping) wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(last_grant) + k) % NREQ;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = IDXW'(cand);
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between NREQ requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU driven) -> RESP (hold result).
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int  WIDTH = 32,
   parameter int  NREQ  = 2,
   localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_op1,
   input  logic [NREQ*WIDTH-1:0] req_op2,
   input  logic [NREQ*3-1:0]     req_ctrl,
   output logic [NREQ-1:0]       req_ready,
   output logic [WIDTH-1:0]      alu_op1,
   output logic [WIDTH-1:0]      alu_op2,
   output logic [2:0]            alu_ctrl,
   input  logic [WIDTH-1:0]      alu_result,
   input  logic                  alu_zero,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_zero,
   output logic                  busy
);

   arb_state_t       state_q, state_d;
   logic [IDXW-1:0]  last_grant_q, last_grant_d;   // also the owner of the in-flight op
   logic [WIDTH-1:0] op1_q, op1_d;
   logic [WIDTH-1:0] op2_q, op2_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_zero_q, rsp_zero_d;

   logic [NREQ-1:0]  arb_gnt;
   logic [IDXW-1:0]  arb_idx;
   logic             req_hs;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .gnt        (arb_gnt),
      .gnt_idx    (arb_idx)
   );

   // Request/response strobes and ALU drive; ALU inputs come only from flops so
   // they hold steady between operations.
   always_comb begin
      req_ready = (state_q == IDLE) ? arb_gnt : '0;
      req_hs    = |(req_valid & req_ready);
      rsp_valid = (state_q == RESP) ? (NREQ'(1) << last_grant_q) : '0;
      alu_op1   = op1_q;
      alu_op2   = op2_q;
      alu_ctrl  = ctrl_q;
      rsp_data  = rsp_data_q;
      rsp_zero  = rsp_zero_q;
      busy      = (state_q != IDLE);
   end

   // Next-state: latch the winner's operands, capture the ALU, wait for the owner to consume.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      ctrl_d       = ctrl_q;
      rsp_data_d   = rsp_data_q;
      rsp_zero_d   = rsp_zero_q;
      case (state_q)
         IDLE: begin
            if (req_hs) begin
               op1_d        = req_op1[int'(arb_idx)*WIDTH +: WIDTH];
               op2_d        = req_op2[int'(arb_idx)*WIDTH +: WIDTH];
               ctrl_d       = req_ctrl[int'(arb_idx)*3 +: 3];
               last_grant_d = arb_idx;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d = alu_result;
            rsp_zero_d = alu_zero;
            state_d    = RESP;
         end
         RESP: begin
            // Only the owner's ready counts; others are ignored.
            if (rsp_ready[last_grant_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset drops any in-flight operation and makes requester 0 win first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= IDXW'(NREQ - 1);
         op1_q        <= '0;
         op2_q        <= '0;
         ctrl_q       <= '0;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         ctrl_q       <= ctrl_d;
         rsp_data_q   <= rsp_data_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   localparam int W = 32;
   localparam int N = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*W-1:0]  req_op1, req_op2;
   logic [N*3-1:0]  req_ctrl;
   logic [N-1:0]    req_ready;
   logic [W-1:0]    alu_op1, alu_op2, alu_result;
   logic [2:0]      alu_ctrl;
   logic            alu_zero;
   logic [N-1:0]    rsp_valid, rsp_ready;
   logic [W-1:0]    rsp_data;
   logic            rsp_zero;
   logic            busy;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
      .req_ready(req_ready),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
   );

   // Reference ALU: returns {zero, result}; unknown codes give 0.
   function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] c);
      logic [W-1:0] r;
      case (c)
         ALU_ADD: r = a + b;
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_SLT: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         default: r = '0;
      endcase
      return {(r == '0), r};
   endfunction

   always_comb {alu_zero, alu_result} = alu_ref(alu_op1, alu_op2, alu_ctrl);

   typedef struct {
      int           idx;
      logic [W-1:0] d;
      logic         z;
   } exp_t;

   exp_t sb[$];
   int   hs_idx[$];
   int   hs_cyc[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   ncyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] c);
      req_op1[i*W +: W] = a;
      req_op2[i*W +: W] = b;
      req_ctrl[i*3 +: 3] = c;
   endtask

   // Observe handshakes at mid-cycle, then advance one clock.
   task automatic cyc();
      exp_t e;
      int   k;
      logic [N-1:0] oh;
      #1;
      if (rst) begin
         sb.delete();
      end else begin
         if (|(req_valid & req_ready)) begin
            k = 0;
            for (int j = 0; j < N; j++) if (req_valid[j] & req_ready[j]) k = j;
            e.idx = k;
            {e.z, e.d} = alu_ref(req_op1[k*W +: W], req_op2[k*W +: W], req_ctrl[k*3 +: 3]);
            sb.push_back(e);
            hs_idx.push_back(k);
            hs_cyc.push_back(ncyc);
         end
         if (|(rsp_valid & rsp_ready)) begin
            if (sb.size() == 0) begin
               chk("spurious_rsp", 64'(rsp_valid), 64'd0);
            end else begin
               e  = sb.pop_front();
               oh = '0;
               oh[e.idx] = 1'b1;
               chk("rsp_sel", 64'(rsp_valid), 64'(oh));
               chk("rsp_data", 64'(rsp_data), 64'(e.d));
               chk("rsp_zero", 64'(rsp_zero), 64'(e.z));
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      ncyc++;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 10) begin cyc(); n++; end
      chk("drain", 64'(sb.size()), 64'd0);
   endtask

   task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] c, input logic [W-1:0] ed, input logic ez);
      int n;
      bit got;
      set_req(i, a, b, c);
      req_valid = '0;
      req_valid[i] = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 10) begin #1; if (req_ready[i]) got = 1'b1; cyc(); n++; end
      chk("single_grant", 64'(got), 64'd1);
      req_valid = '0;
      n = 0; got = 1'b0;
      while (!got && n < 10) begin
         #1;
         if (rsp_valid[i]) begin
            got = 1'b1;
            chk("single_data", 64'(rsp_data), 64'(ed));
            chk("single_zero", 64'(rsp_zero), 64'(ez));
         end
         cyc();
         n++;
      end
      chk("single_rsp", 64'(got), 64'd1);
   endtask

   initial begin
      int exp_order [4];
      int n;
      logic [W-1:0] held;
      exp_order = '{0, 1, 0, 1};

      // Reset state
      rst = 1'b1; req_valid = '0; req_op1 = '0; req_op2 = '0; req_ctrl = '0; rsp_ready = '0;
      @(negedge clk); cyc(); cyc();
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_alu_op1", 64'(alu_op1), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      rst = 1'b0;
      cyc();

      // ADD 5+7 from requester 0, latency and busy
      set_req(0, 32'd5, 32'd7, ALU_ADD);
      req_valid = 2'b01;
      #1 chk("t1_ready", 64'(req_ready), 64'b01);
      cyc();
      req_valid = '0;
      #1;
      chk("t1_exec_busy", 64'(busy), 64'd1);
      chk("t1_exec_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t1_exec_ready", 64'(req_ready), 64'd0);
      chk("t1_exec_alu_op1", 64'(alu_op1), 64'd5);
      cyc();
      #1;
      chk("t1_rsp_valid", 64'(rsp_valid), 64'b01);
      chk("t1_rsp_data", 64'(rsp_data), 64'd12);
      chk("t1_rsp_zero", 64'(rsp_zero), 64'd0);
      chk("t1_rsp_busy", 64'(busy), 64'd1);
      rsp_ready = 2'b11;
      cyc();
      #1;
      chk("t1_idle_busy", 64'(busy), 64'd0);
      chk("t1_alu_hold", 64'(alu_op2), 64'd7);

      // SUB 9-9 -> zero flag
      single(0, 32'd9, 32'd9, ALU_SUB, 32'd0, 1'b1);

      // Round-robin fairness from a fresh reset
      rst = 1'b1; cyc(); rst = 1'b0;
      hs_idx.delete(); hs_cyc.delete();
      set_req(0, 32'd5, 32'd7, ALU_ADD);
      set_req(1, 32'd20, 32'd6, ALU_SUB);
      req_valid = 2'b11;
      n = 0;
      while (hs_idx.size() < 4 && n < 40) begin cyc(); n++; end
      req_valid = '0;
      chk("t3_hs_count", 64'(hs_idx.size()), 64'd4);
      if (hs_idx.size() == 4) begin
         for (int k = 0; k < 4; k++) chk($sformatf("t3_order%0d", k), 64'(hs_idx[k]), 64'(exp_order[k]));
         for (int k = 1; k < 4; k++) chk($sformatf("t3_period%0d", k), 64'(hs_cyc[k] - hs_cyc[k-1]), 64'd3);
      end
      drain();

      // Stall in RESP: wrong-requester ready ignored, req1 waits
      rsp_ready = 2'b10;
      set_req(0, 32'd100, 32'd1, ALU_ADD);
      req_valid = 2'b01;
      cyc();
      set_req(1, 32'd48, 32'd3, ALU_OR);
      req_valid = 2'b10;
      cyc();
      held = rsp_data;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t4_stall_valid", 64'(rsp_valid), 64'b01);
         chk("t4_stall_data", 64'(rsp_data), 64'd101);
         chk("t4_stall_stable", 64'(rsp_data), 64'(held));
         chk("t4_stall_ready", 64'(req_ready), 64'd0);
         cyc();
      end
      rsp_ready = 2'b11;
      #1 chk("t4_release_ready", 64'(req_ready), 64'd0);
      cyc();
      #1 chk("t4_req1_granted", 64'(req_ready), 64'b10);
      cyc();
      req_valid = '0;
      drain();

      // Reset during EXEC drops the operation
      set_req(0, 32'd7, 32'd7, ALU_AND);
      req_valid = 2'b01;
      cyc();
      req_valid = '0;
      #1 chk("t5_exec_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      cyc();
      #1;
      chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t5_rst_busy", 64'(busy), 64'd0);
      chk("t5_rst_alu_op1", 64'(alu_op1), 64'd0);
      chk("t5_rst_rsp_data", 64'(rsp_data), 64'd0);
      rst = 1'b0;
      repeat (3) begin cyc(); #1 chk("t5_no_rsp", 64'(rsp_valid), 64'd0); end
      set_req(1, 32'd1, 32'd2, ALU_ADD);
      req_valid = 2'b11;
      #1 chk("t5_req0_first", 64'(req_ready), 64'b01);
      cyc();
      req_valid = '0;
      drain();

      // SLT and an unused control code
      single(0, 32'd3, 32'd8, 3'b101, 32'd1, 1'b0);
      single(1, 32'd3, 32'd8, 3'b111, 32'd0, 1'b1);

      chk("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
